// File: rtl/dct_seq_ctrl.sv
// dct_seq_ctrl: sequencer for the 8-point 1D-DCT datapath; clears the datapath, loads I0..I7 over a valid/ready handshake, strobes butterfly, scale and sign steps, then presents coefficients 0..7 over an output handshake
module dct_seq_ctrl #(
  parameter int DW = 8,
  parameter int NPT = 8,
  parameter int BFLY_CYCLES = 6,
  localparam int IW = $clog2(NPT),
  localparam int CW = $clog2(BFLY_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ld_en,
  output logic [IW-1:0] ld_idx,
  output logic [DW-1:0] ld_data,
  output logic          dp_clr,
  output logic          calc_en,
  output logic          scale_en,
  output logic          sign_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, CALC, SCALE, SIGN, OUT} state_t;
  localparam logic [IW-1:0] LAST = IW'(NPT - 1);
  localparam logic [CW-1:0] CLAST = CW'(BFLY_CYCLES - 1);
  state_t state, state_n;
  logic [IW-1:0] ld_cnt, out_idx_n;
  logic [CW-1:0] cc;
  logic out_hs, dp_clr_n, calc_en_n, scale_en_n, sign_en_n, out_valid_n, busy_n, done_n;
  assign in_ready = state == LOAD;
  assign ld_en = in_valid & in_ready;
  assign ld_idx = ld_cnt;
  assign ld_data = in_data;
  assign out_hs = out_valid & out_ready;
  assign out_last = out_valid && out_idx == LAST;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CLR : IDLE;
      CLR:     state_n = LOAD;
      LOAD:    state_n = (ld_en && ld_cnt == LAST) ? CALC : LOAD;
      CALC:    state_n = (cc == CLAST) ? SCALE : CALC;
      SCALE:   state_n = SIGN;
      SIGN:    state_n = OUT;
      OUT:     state_n = (out_hs && out_idx == LAST) ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    dp_clr_n = state_n == CLR;
    calc_en_n = state_n == CALC;
    scale_en_n = state_n == SCALE;
    sign_en_n = state_n == SIGN;
    out_valid_n = state_n == OUT;
    busy_n = state_n != IDLE;
    done_n = state == OUT && state_n == IDLE;
    out_idx_n = state_n != OUT ? '0 : out_hs ? out_idx + 1'b1 : out_idx;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      ld_cnt <= '0;
      cc <= '0;
      out_idx <= '0;
      dp_clr <= 1'b0;
      calc_en <= 1'b0;
      scale_en <= 1'b0;
      sign_en <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      ld_cnt <= state_n != LOAD ? '0 : ld_en ? ld_cnt + 1'b1 : ld_cnt;
      cc <= state == CALC ? cc + 1'b1 : '0;
      out_idx <= out_idx_n;
      dp_clr <= dp_clr_n;
      calc_en <= calc_en_n;
      scale_en <= scale_en_n;
      sign_en <= sign_en_n;
      out_valid <= out_valid_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_dct_seq_ctrl.sv
// tb_dct_seq_ctrl: directed self-checking bench for dct_seq_ctrl
module tb_dct_seq_ctrl;
  logic clk = 1'b0, clr, start, in_valid, out_ready;
  logic [7:0] in_data, ld_data;
  logic [2:0] ld_idx, out_idx;
  logic in_ready, ld_en, dp_clr, calc_en, scale_en, sign_en, out_valid, out_last, busy, done;
  int total = 0, passed = 0;
  logic [7:0] samp [8] = '{8'd10, -8'sd3, 8'd7, 8'd0, -8'sd128, 8'd127, 8'd5, -8'sd1};
  always #5 clk = ~clk;
  dct_seq_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .dp_clr(dp_clr), .calc_en(calc_en), .scale_en(scale_en), .sign_en(sign_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [31:0] strobes();
    return {24'd0, dp_clr, ld_en, calc_en, scale_en, sign_en, out_valid, busy, done};
  endfunction
  task automatic idle_zero(input string tag);
    chk(tag, {strobes(), in_ready, out_last, ld_idx, out_idx}, '0);
  endtask
  task automatic block(input bit gaps, input bit stall, input bit poke, input int abort_k);
    int i, cyc, j, st;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_cycle", strobes(), 32'b1000_0010);
    chk("clr_in_ready", in_ready, 0);
    @(negedge clk);
    i = 0;
    cyc = 0;
    while (i < 8 && cyc < 100) begin
      in_valid = gaps ? (cyc % 3 == 0) : 1'b1;
      in_data = samp[i];
      start = poke && cyc == 3;
      #1;
      chk("load_in_ready", in_ready, 1);
      chk("load_ld_en", ld_en, in_valid);
      chk("load_no_strobe", {dp_clr, calc_en, scale_en, sign_en, out_valid}, 0);
      if (in_valid) begin
        chk("ld_idx", ld_idx, i);
        chk("ld_data", ld_data, samp[i]);
      end
      @(negedge clk);
      if (in_valid) i++;
      cyc++;
    end
    chk("load_count", i, 8);
    in_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      start = poke && k == 1;
      chk("calc_cycle", strobes(), 32'b0010_0010);
      chk("calc_in_ready", in_ready, 0);
      if (k == abort_k) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        idle_zero("abort_zero");
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("scale_cycle", strobes(), 32'b0001_0010);
    @(negedge clk);
    chk("sign_cycle", strobes(), 32'b0000_1010);
    @(negedge clk);
    j = 0;
    st = 0;
    cyc = 0;
    while (j < 8 && cyc < 100) begin
      out_ready = !(stall && j == 2 && st < 3);
      start = poke && j == 4;
      #1;
      chk("out_cycle", strobes(), 32'b0000_0110);
      chk("out_idx", out_idx, j);
      chk("out_last", out_last, j == 7);
      @(negedge clk);
      if (out_ready) j++;
      else st++;
      cyc++;
    end
    chk("out_count", j, 8);
    out_ready = 1'b0;
    start = 1'b0;
    chk("done_cycle", strobes(), 32'b0000_0001);
    @(negedge clk);
    chk("after_done", strobes(), 0);
  endtask
  initial begin
    clr = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle_zero("reset_zero");
    clr = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("idle_no_accept", {in_ready, ld_en}, 0);
    in_valid = 1'b0;
    @(negedge clk);
    block(1'b0, 1'b0, 1'b0, -1);
    block(1'b1, 1'b1, 1'b0, -1);
    block(1'b0, 1'b0, 1'b1, -1);
    block(1'b0, 1'b0, 1'b0, 2);
    block(1'b0, 1'b0, 1'b0, -1);
    start = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
    idle_zero("mid_load_abort");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_after_clr", strobes(), 32'b1000_0010);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
